// File: rtl/vedic_pkg.sv
// Shared constants, partial-product bundle and the 2x2 Urdhva cell.
package vedic_pkg;

    localparam int unsigned VM_WIDTH = 8;
    localparam int unsigned VM_PW    = 16;
    localparam int unsigned VM_HALF  = 4;

    // Four 4x4 partial products passed from the multiply stage to the combine stage
    typedef struct packed {
        logic [7:0] ll;
        logic [7:0] lh;
        logic [7:0] hl;
        logic [7:0] hh;
    } pp_t;

    // 2x2 vertical-and-crosswise cell: vertical a0b0, crosswise a1b0^a0b1, vertical a1b1
    function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
        logic v0, x0, x1, c1, v1;
        v0 = a[0] & b[0];
        x0 = a[1] & b[0];
        x1 = a[0] & b[1];
        c1 = x0 & x1;
        v1 = a[1] & b[1];
        return {v1 & c1, v1 ^ c1, x0 ^ x1, v0};
    endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 Urdhva multiplier built from four 2x2 cells.
module vedic_4x4
    import vedic_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [3:0] q_ll;
    logic [3:0] q_hl;
    logic [3:0] q_lh;
    logic [3:0] q_hh;
    logic [4:0] mid;

    // Cross terms share weight 4 and are summed at 5 bits before combining
    always_comb begin
        q_ll = mul2x2(a[1:0], b[1:0]);
        q_hl = mul2x2(a[3:2], b[1:0]);
        q_lh = mul2x2(a[1:0], b[3:2]);
        q_hh = mul2x2(a[3:2], b[3:2]);
        mid  = {1'b0, q_hl} + {1'b0, q_lh};
        p    = {q_hh, q_ll} + {1'b0, mid, 2'b00};
    end

endmodule

// File: rtl/vedic_mult8_pipe.sv
// Streaming 8x8 Vedic multiplier: operand, partial-product, product and output register ranks
// moving in lockstep under a single advance signal.
module vedic_mult8_pipe
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = VM_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [CNT_W-1:0]   done_cnt,
    output logic               act_led
);

    logic               advance;
    logic               handoff;

    logic               s1_valid_q;
    logic [WIDTH-1:0]   s1_a_q;
    logic [WIDTH-1:0]   s1_b_q;
    logic               s2_valid_q;
    pp_t                s2_pp_q;
    logic               s3_valid_q;
    logic [VM_PW-1:0]   s3_p_q;
    logic               out_valid_q;
    logic [VM_PW-1:0]   out_p_q;
    logic [CNT_W-1:0]   done_cnt_q;
    logic               act_led_q;

    logic [7:0]         ll;
    logic [7:0]         lh;
    logic [7:0]         hl;
    logic [7:0]         hh;
    pp_t                pp_d;
    logic [8:0]         mid_sum;
    logic [VM_PW-1:0]   p_d;

    vedic_4x4 u_ll (.a(s1_a_q[VM_HALF-1:0]),     .b(s1_b_q[VM_HALF-1:0]),     .p(ll));
    vedic_4x4 u_lh (.a(s1_a_q[VM_HALF-1:0]),     .b(s1_b_q[WIDTH-1:VM_HALF]), .p(lh));
    vedic_4x4 u_hl (.a(s1_a_q[WIDTH-1:VM_HALF]), .b(s1_b_q[VM_HALF-1:0]),     .p(hl));
    vedic_4x4 u_hh (.a(s1_a_q[WIDTH-1:VM_HALF]), .b(s1_b_q[WIDTH-1:VM_HALF]), .p(hh));

    // Handshake: the whole pipe moves whenever the output slot is empty or being drained
    always_comb begin
        advance = ~out_valid_q | out_ready;
        handoff = out_valid_q & out_ready;
    end

    // Combine: 9-bit middle sum so 0xFF*0xFF stays exact
    always_comb begin
        pp_d    = '{ll: ll, lh: lh, hl: hl, hh: hh};
        mid_sum = {1'b0, s2_pp_q.lh} + {1'b0, s2_pp_q.hl};
        p_d     = {s2_pp_q.hh, s2_pp_q.ll} + {3'b000, mid_sum, 4'b0000};
    end

    // Pipeline ranks; data only loads behind a valid bit so bubbles leave data untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_pp_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_p_q      <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            if (in_valid) begin
                s1_a_q <= in_a;
                s1_b_q <= in_b;
            end
            if (s1_valid_q) s2_pp_q <= pp_d;
            if (s2_valid_q) s3_p_q  <= p_d;
            if (s3_valid_q) out_p_q <= s3_p_q;
        end
    end

    // Handoff bookkeeping: wrapping product counter and LED toggle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
            act_led_q  <= 1'b0;
        end else if (handoff) begin
            done_cnt_q <= done_cnt_q + CNT_W'(1);
            act_led_q  <= ~act_led_q;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign done_cnt  = done_cnt_q;
    assign act_led   = act_led_q;

endmodule
